inst_refill_engine: RTL and testbench

//  Write-side companion of the I-cache data array: on a miss, fetches one 64-byte line from
//  the memory bus as 16 x 32-bit beats, assembles it, writes it into the selected way in one cycle.

---
 rtl/inst_refill_engine_pkg.sv | 29 ++
 rtl/inst_refill_engine_line_buffer.sv | 47 ++++
 rtl/inst_refill_engine.sv | 168 ++++++++++++++++
 tb/tb_inst_refill_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_refill_engine_pkg.sv
// -----------------------------------------------------------------------------
// inst_refill_engine_pkg
// Shared I-cache constants and types used by the refill engine and its line
// buffer: line geometry, address split, refill FSM state encoding and a
// line-alignment helper.
// -----------------------------------------------------------------------------
package inst_refill_engine_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int LINE_WORDS  = 16;
  localparam int WAYS        = 4;
  localparam int LINE_BITS   = WORD_W * LINE_WORDS;  // 512
  localparam int OFFSET_BITS = 6;                    // 64-byte line
  localparam int INDEX_BITS  = 6;                    // set index = addr[11:6]

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    WRITE
  } refill_state_e;

  // Clears the byte-offset bits so the address points at the start of its line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/inst_refill_engine_line_buffer.sv
// -----------------------------------------------------------------------------
// refill_line_buffer
// Assembly buffer for one cache line: word-addressed write of one beat per
// cycle, full-line parallel read. The read view already includes the word being
// written this cycle, so the engine can capture a complete line on the same
// edge that stores its final beat.
// Ports:
//   clk       in   clock
//   i_we      in   write the word at i_idx this cycle
//   i_idx     in   word slot to write
//   i_data    in   word to write
//   o_line    out  line contents, word k at bits [WORD_W*k +: WORD_W]
// -----------------------------------------------------------------------------
module refill_line_buffer #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 16,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [IDX_W-1:0]             i_idx,
  input  logic [WORD_W-1:0]            i_data,
  output logic [WORD_W*LINE_WORDS-1:0] o_line
);

  logic [WORD_W-1:0] r_mem [LINE_WORDS];

  // NOTE: storage arrays carry no reset; slots not written by a fill simply keep
  // stale data, which is the intended behaviour on a truncated burst.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_data;
    end
  end

  // Forward the incoming word so the view equals the contents after this edge.
  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (i_we && (i_idx == IDX_W'(k))) begin
        o_line[k*WORD_W +: WORD_W] = i_data;
      end else begin
        o_line[k*WORD_W +: WORD_W] = r_mem[k];
      end
    end
  end

endmodule

// File: rtl/inst_refill_engine.sv
// -----------------------------------------------------------------------------
// inst_refill_engine
// Write-side companion of the I-cache data array. Accepts a miss, issues one
// line-aligned bus read, assembles LINE_WORDS return beats and writes the whole
// line into the selected way in a single cycle.
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   i_miss_req/o_miss_ready     miss handshake (ready only while idle)
//   i_miss_addr, i_miss_way     missing byte address, one-hot victim way
//   o_rd_req, o_rd_addr, i_rd_rdy           bus read request (held until i_rd_rdy)
//   i_ret_valid, i_ret_last, i_ret_data     bus return beats
//   o_w_addr, o_mem_din, o_mem_we           data-array write port
//   o_fill_done                 one-cycle pulse with o_mem_we
//   o_proto_err                 sticky: burst length did not match the line
// -----------------------------------------------------------------------------
module inst_refill_engine
  import inst_refill_engine_pkg::*;
#(
  parameter int WORD_W     = inst_refill_engine_pkg::WORD_W,
  parameter int LINE_WORDS = inst_refill_engine_pkg::LINE_WORDS,
  parameter int WAYS       = inst_refill_engine_pkg::WAYS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_miss_req,
  input  logic [ADDR_W-1:0]            i_miss_addr,
  input  logic [WAYS-1:0]              i_miss_way,
  output logic                         o_miss_ready,
  output logic                         o_rd_req,
  output logic [ADDR_W-1:0]            o_rd_addr,
  input  logic                         i_rd_rdy,
  input  logic                         i_ret_valid,
  input  logic                         i_ret_last,
  input  logic [WORD_W-1:0]            i_ret_data,
  output logic [ADDR_W-1:0]            o_w_addr,
  output logic [WORD_W*LINE_WORDS-1:0] o_mem_din,
  output logic [WAYS-1:0]              o_mem_we,
  output logic                         o_fill_done,
  output logic                         o_proto_err
);

  localparam int                BEAT_W    = $clog2(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  refill_state_e               r_state;
  refill_state_e               w_state_next;
  logic [BEAT_W-1:0]           r_beat_cnt;
  logic [ADDR_W-1:0]           r_addr;
  logic [WAYS-1:0]             r_way;
  logic                        r_proto_err;
  logic [ADDR_W-1:0]           r_w_addr;
  logic [WORD_W*LINE_WORDS-1:0] r_mem_din;

  logic                        w_accept;
  logic                        w_buf_we;
  logic                        w_fill_load;
  logic                        w_set_err;
  logic [WORD_W*LINE_WORDS-1:0] w_line;

  // Byte-offset bits are dropped by line alignment; fold them here so the
  // intentionally ignored input bits are explicit.
  logic w_unused_offset;
  assign w_unused_offset = ^i_miss_addr[OFFSET_BITS-1:0];

  refill_line_buffer #(
    .WORD_W     (WORD_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buffer (
    .clk    (clk),
    .i_we   (w_buf_we),
    .i_idx  (r_beat_cnt),
    .i_data (i_ret_data),
    .o_line (w_line)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_buf_we     = 1'b0;
    w_fill_load  = 1'b0;
    w_set_err    = 1'b0;
    o_miss_ready = 1'b0;
    o_rd_req     = 1'b0;
    o_mem_we     = '0;
    o_fill_done  = 1'b0;
    case (r_state)
      IDLE: begin
        o_miss_ready = 1'b1;
        if (i_miss_req) begin
          w_accept     = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        o_rd_req = 1'b1;
        if (i_rd_rdy) begin
          w_state_next = RECV;
        end
      end
      RECV: begin
        if (i_ret_valid) begin
          w_buf_we = 1'b1;
          // The final slot always closes the fill; ret_last must agree with it.
          if (r_beat_cnt == LAST_BEAT) begin
            w_fill_load  = 1'b1;
            w_set_err    = !i_ret_last;
            w_state_next = WRITE;
          end else if (i_ret_last) begin
            w_fill_load  = 1'b1;
            w_set_err    = 1'b1;
            w_state_next = WRITE;
          end
        end
      end
      WRITE: begin
        o_mem_we     = r_way;
        o_fill_done  = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_addr      <= '0;
      r_way       <= '0;
      r_proto_err <= 1'b0;
      r_w_addr    <= '0;
      r_mem_din   <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= line_align(i_miss_addr);
        r_way      <= i_miss_way;
        r_beat_cnt <= '0;
      end else if (w_buf_we) begin
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      end
      if (w_set_err) begin
        r_proto_err <= 1'b1;
      end
      // Write-port registers load on entry to WRITE and hold afterwards.
      if (w_fill_load) begin
        r_w_addr  <= r_addr;
        r_mem_din <= w_line;
      end
    end
  end

  assign o_rd_addr   = r_addr;
  assign o_w_addr    = r_w_addr;
  assign o_mem_din   = r_mem_din;
  assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_inst_refill_engine.sv
// -----------------------------------------------------------------------------
// tb_inst_refill_engine
// Directed self-checking bench for inst_refill_engine: reset, normal fill,
// stalled bus with gapped beats, busy rejection, early ret_last, missing
// ret_last, reset mid-burst.
// -----------------------------------------------------------------------------
module tb_inst_refill_engine;

  logic         clk;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic [3:0]   miss_way;
  logic         miss_ready;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic [31:0]  w_addr;
  logic [511:0] mem_din;
  logic [3:0]   mem_we;
  logic         fill_done;
  logic         proto_err;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int rdreq_rise = 0;
  logic rd_req_q = 1'b0;

  // Reference copy of the line buffer, including stale words.
  logic [31:0] m_buf [16];

  inst_refill_engine dut (
    .clk          (clk),
    .rst          (rst),
    .i_miss_req   (miss_req),
    .i_miss_addr  (miss_addr),
    .i_miss_way   (miss_way),
    .o_miss_ready (miss_ready),
    .o_rd_req     (rd_req),
    .o_rd_addr    (rd_addr),
    .i_rd_rdy     (rd_rdy),
    .i_ret_valid  (ret_valid),
    .i_ret_last   (ret_last),
    .i_ret_data   (ret_data),
    .o_w_addr     (w_addr),
    .o_mem_din    (mem_din),
    .o_mem_we     (mem_we),
    .o_fill_done  (fill_done),
    .o_proto_err  (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count write pulses and read-request starts as seen at each clock edge.
  always @(posedge clk) begin
    if (mem_we != 4'b0000) we_cnt = we_cnt + 1;
    if (rd_req && !rd_req_q) rdreq_rise = rdreq_rise + 1;
    rd_req_q = rd_req;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] exp_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = m_buf[k];
    return l;
  endfunction

  // One complete miss. last_at < 0 means ret_last is never asserted.
  task automatic run_fill(input logic [31:0] addr, input logic [3:0] way,
                          input int stall, input int gap, input int nbeats,
                          input int last_at, input logic [31:0] base,
                          input logic busy_poke, input logic exp_err);
    int we0;
    int rq0;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:6], 6'b0};
    we0 = we_cnt;
    rq0 = rdreq_rise;
    check("ready_idle", miss_ready, 1'b1);
    miss_req  = 1'b1;
    miss_addr = addr;
    miss_way  = way;
    tick();
    miss_req  = 1'b0;
    check("rd_req_up", rd_req, 1'b1);
    check("rd_addr", rd_addr, exp_addr);
    check("ready_busy", miss_ready, 1'b0);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("rd_req_held", rd_req, 1'b1);
      check("rd_addr_held", rd_addr, exp_addr);
    end
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    check("rd_req_down", rd_req, 1'b0);
    for (int i = 0; i < nbeats; i++) begin
      for (int g = 0; g < gap; g++) begin
        ret_valid = 1'b0;
        tick();
      end
      if (busy_poke) begin
        miss_req  = 1'b1;
        miss_addr = 32'h0000_F000;
        check("busy_ready", miss_ready, 1'b0);
      end
      ret_valid = 1'b1;
      ret_data  = base + 32'(i);
      ret_last  = (i == last_at);
      m_buf[i]  = base + 32'(i);
      check("no_early_we", mem_we, 4'b0000);
      tick();
    end
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    miss_req  = 1'b0;
    // WRITE cycle
    check("mem_we", mem_we, way);
    check("fill_done", fill_done, 1'b1);
    check("w_addr", w_addr, exp_addr);
    check("mem_din", mem_din, exp_line());
    check("proto_err", proto_err, exp_err);
    tick();
    check("mem_we_off", mem_we, 4'b0000);
    check("fill_done_off", fill_done, 1'b0);
    check("ready_back", miss_ready, 1'b1);
    check("w_addr_hold", w_addr, exp_addr);
    check("mem_din_hold", mem_din, exp_line());
    tick();
    check("no_second_rd", rd_req, 1'b0);
    check("we_pulses", 32'(we_cnt - we0), 32'd1);
    check("rd_starts", 32'(rdreq_rise - rq0), 32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    miss_req  = 1'b0;
    miss_addr = '0;
    miss_way  = '0;
    rd_rdy    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = '0;

    // 1: asynchronous reset, observed before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_ready", miss_ready, 1'b1);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_mem_we", mem_we, 4'b0000);
    check("rst_fill_done", fill_done, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_w_addr", w_addr, 32'h0);
    check("rst_mem_din", mem_din, 512'h0);
    tick();
    rst = 1'b0;
    tick();

    // 2: normal fill, back-to-back beats
    run_fill(32'h0000_1A7C, 4'b0100, 0, 0, 16, 15, 32'h100, 1'b0, 1'b0);
    // 3: stalled bus, beats every other cycle
    run_fill(32'hDEAD_BEEF, 4'b0001, 5, 1, 16, 15, 32'h100, 1'b0, 1'b0);
    // 4: miss requests during RECV are ignored
    run_fill(32'h0000_3FC4, 4'b0010, 0, 0, 16, 15, 32'h300, 1'b1, 1'b0);
    // 5: ret_last on beat 9; words 10..15 keep the previous line
    run_fill(32'h1234_5678, 4'b1000, 1, 0, 10, 9, 32'h500, 1'b0, 1'b1);
    // error stays sticky across a clean fill
    run_fill(32'h0000_0800, 4'b0100, 0, 0, 16, 15, 32'h700, 1'b0, 1'b1);

    // 6: reset mid-burst after 7 beats
    begin
      int we0;
      we0 = we_cnt;
      miss_req  = 1'b1;
      miss_addr = 32'h0000_0FC0;
      miss_way  = 4'b0010;
      tick();
      miss_req = 1'b0;
      rd_rdy   = 1'b1;
      tick();
      rd_rdy = 1'b0;
      for (int i = 0; i < 7; i++) begin
        ret_valid = 1'b1;
        ret_data  = 32'h900 + 32'(i);
        m_buf[i]  = 32'h900 + 32'(i);
        tick();
      end
      ret_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_ready", miss_ready, 1'b1);
      check("mid_rst_rd_req", rd_req, 1'b0);
      check("mid_rst_err", proto_err, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("mid_rst_no_we", 32'(we_cnt - we0), 32'd0);
    end
    run_fill(32'h0000_0040, 4'b1000, 0, 0, 16, 15, 32'hA00, 1'b0, 1'b0);

    // 7: no ret_last on beat 15 -> fill completes, error flagged
    run_fill(32'h8000_01C0, 4'b0001, 0, 0, 16, -1, 32'hC00, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
